// File: rtl/io_post_buffer.sv
// io_post_buffer: posts CPU IO writes into a small ordered FIFO and replays them to the IO domain.
// Depth is 1 entry by default; define POSTBUF_DEPTH2_EN for a 2-entry buffer.
module io_post_buffer (
    input  logic        CLK,
    input  logic        nRES,
    input  logic [23:1] A,
    input  logic [15:0] D,
    input  logic        nUDS,
    input  logic        nLDS,
    input  logic        nWE,
    input  logic        BACT,
    input  logic        IOPWCS,
    output logic        PostACK,
    output logic        PostEmpty,
    output logic        PostFull,
    output logic        IOREQ,
    output logic [23:1] IOA,
    output logic [15:0] IOD,
    output logic        IOnUDS,
    output logic        IOnLDS,
    input  logic        IOACK
);
`ifdef POSTBUF_DEPTH2_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif
    typedef enum logic {WAIT, ACKED} cap_e;
    typedef enum logic [1:0] {IDLE, REQ, RECOV} drn_e;
    logic [40:0] mem_q [4];
    logic [40:0] head;
    logic [1:0]  wptr_q, wptr_d, rptr_q, rptr_d, cnt_q, cnt_d;
    cap_e        cap_q;
    drn_e        drn_q;
    logic        postack_q, ioreq_q, iouds_q, iolds_q;
    logic [23:1] ioa_q;
    logic [15:0] iod_q;
    logic        push, pop;

    assign PostEmpty = cnt_q == 2'd0;
    assign PostFull  = cnt_q == DEPTH;
    // stall decision uses the pre-edge full flag, so a pop frees the slot one cycle later
    assign push      = BACT & IOPWCS & ~nWE & ~PostFull & (cap_q == WAIT);
    assign pop       = (drn_q == REQ) & IOACK;
    assign head      = mem_q[rptr_q];

    always_comb begin
        wptr_d = push ? ((wptr_q == DEPTH - 2'd1) ? 2'd0 : wptr_q + 2'd1) : wptr_q;
        rptr_d = pop ? ((rptr_q == DEPTH - 2'd1) ? 2'd0 : rptr_q + 2'd1) : rptr_q;
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wptr_q] <= {A, D, nUDS, nLDS};
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            wptr_q    <= 2'd0;
            rptr_q    <= 2'd0;
            cnt_q     <= 2'd0;
            cap_q     <= WAIT;
            drn_q     <= IDLE;
            postack_q <= 1'b0;
            ioreq_q   <= 1'b0;
            ioa_q     <= '0;
            iod_q     <= '0;
            iouds_q   <= 1'b1;
            iolds_q   <= 1'b1;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            case (cap_q)
                WAIT: if (push) begin
                    cap_q     <= ACKED;
                    postack_q <= 1'b1;
                end
                ACKED: if (!BACT) begin
                    cap_q     <= WAIT;
                    postack_q <= 1'b0;
                end
            endcase
            case (drn_q)
                IDLE: if (!PostEmpty) begin
                    drn_q   <= REQ;
                    ioreq_q <= 1'b1;
                    {ioa_q, iod_q, iouds_q, iolds_q} <= head;
                end
                REQ: if (IOACK) begin
                    drn_q   <= RECOV;
                    ioreq_q <= 1'b0;
                end
                RECOV: drn_q <= IDLE;
                default: begin
                    drn_q   <= IDLE;
                    ioreq_q <= 1'b0;
                end
            endcase
        end
    end

    assign PostACK = postack_q;
    assign IOREQ   = ioreq_q;
    assign IOA     = ioa_q;
    assign IOD     = iod_q;
    assign IOnUDS  = iouds_q;
    assign IOnLDS  = iolds_q;
endmodule

// File: tb/tb_io_post_buffer.sv
// tb_io_post_buffer: table-driven vectors plus scoreboarded multi-cycle sequences for io_post_buffer.
module tb_io_post_buffer;
`ifdef POSTBUF_DEPTH2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    logic        CLK = 1'b0, nRES = 1'b0;
    logic [23:1] A = '0;
    logic [15:0] D = '0;
    logic        nUDS = 1'b1, nLDS = 1'b1, nWE = 1'b1, BACT = 1'b0, IOPWCS = 1'b0, IOACK = 1'b0;
    logic        PostACK, PostEmpty, PostFull, IOREQ, IOnUDS, IOnLDS;
    logic [23:1] IOA;
    logic [15:0] IOD;
    int          checks = 0, errors = 0;
    logic [40:0] sb [$];

    typedef struct {
        logic [23:1] a;
        logic [15:0] d;
        logic        u, l, we, pw, ack;
    } vec_t;
    vec_t tbl [6];

    io_post_buffer dut (
        .CLK(CLK), .nRES(nRES), .A(A), .D(D), .nUDS(nUDS), .nLDS(nLDS), .nWE(nWE),
        .BACT(BACT), .IOPWCS(IOPWCS), .PostACK(PostACK), .PostEmpty(PostEmpty),
        .PostFull(PostFull), .IOREQ(IOREQ), .IOA(IOA), .IOD(IOD), .IOnUDS(IOnUDS),
        .IOnLDS(IOnLDS), .IOACK(IOACK)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [23:1] a, input logic [15:0] d, input logic u, input logic l,
                      input logic we, input logic pw, output logic acked);
        A = a; D = d; nUDS = u; nLDS = l; nWE = we; IOPWCS = pw; BACT = 1'b1; acked = 1'b0;
        for (int i = 0; i < 4 && !acked; i++) begin
            tick;
            acked = PostACK;
        end
        if (acked) sb.push_back({a, d, u, l});
        BACT = 1'b0;
        tick;
        IOPWCS = 1'b0; nWE = 1'b1;
    endtask

    task automatic drain_one(input string nm);
        logic [40:0] e;
        int n;
        n = 0;
        while (!IOREQ && n < 20) begin
            tick;
            n++;
        end
        chk({nm, " req"}, IOREQ, 1);
        if (IOREQ) begin
            e = (sb.size() > 0) ? sb.pop_front() : '1;
            chk({nm, " entry"}, {IOA, IOD, IOnUDS, IOnLDS}, e);
            tick;
            chk({nm, " hold"}, {IOREQ, IOA, IOD, IOnUDS, IOnLDS}, {1'b1, e});
            IOACK = 1'b1;
            tick;
            IOACK = 1'b0;
            chk({nm, " recov"}, IOREQ, 0);
        end
    endtask

    initial begin
        logic        ak;
        logic [40:0] e;
        int          bad, highs, viol, left;
        logic        gap, prev;
        tbl[0] = '{23'h3FA100, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{23'h000002, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{23'h7FFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{23'h123456, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{23'h654321, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{23'h000000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        #12;
        chk("reset outputs", {PostACK, IOREQ, PostEmpty, PostFull, IOnUDS, IOnLDS}, 6'b001011);
        chk("reset ioa/iod", {IOA, IOD}, 0);
        nRES = 1'b1;
        tick;

        // single posted write, cycle by cycle
        A = 23'h3FA100; D = 16'h1234; nUDS = 1'b0; nLDS = 1'b0; nWE = 1'b0; IOPWCS = 1'b1; BACT = 1'b1;
        tick;
        chk("single ack", {PostACK, PostEmpty, IOREQ}, 3'b100);
        BACT = 1'b0;
        tick;
        chk("single req", {PostACK, IOREQ}, 2'b01);
        chk("single ioa/iod", {IOA, IOD}, {23'h3FA100, 16'h1234});
        IOACK = 1'b1;
        tick;
        IOACK = 1'b0;
        chk("single pop", {IOREQ, PostEmpty}, 2'b01);
        tick;
        chk("single idle", {IOREQ, PostEmpty}, 2'b01);
        IOPWCS = 1'b0; nWE = 1'b1;

        // non-candidate cycle held 6 cycles
        A = 23'h111111; D = 16'h9999; nWE = 1'b0; IOPWCS = 1'b0; BACT = 1'b1; bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (PostACK || IOREQ || !PostEmpty) bad++;
        end
        BACT = 1'b0; nWE = 1'b1;
        tick;
        chk("ignored pwcs", bad, 0);

        for (int i = 0; i < 6; i++) begin
            wr(tbl[i].a, tbl[i].d, tbl[i].u, tbl[i].l, tbl[i].we, tbl[i].pw, ak);
            chk($sformatf("tbl%0d ack", i), ak, tbl[i].ack);
            if (ak) drain_one($sformatf("tbl%0d", i));
            else chk($sformatf("tbl%0d idle", i), {IOREQ, PostEmpty}, 2'b01);
        end

`ifdef POSTBUF_DEPTH2_EN
        nUDS = 1'b0; nLDS = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            A = 23'h000100; D = 16'(i); nWE = 1'b0; IOPWCS = 1'b1; BACT = 1'b1;
            tick;
            chk($sformatf("d2 w%0d ack", i), PostACK, 1);
            sb.push_back({A, D, 2'b00});
            BACT = 1'b0;
            tick;
        end
        A = 23'h000100; D = 16'h0003; BACT = 1'b1;
        tick;
        chk("d2 w3 stall", {PostACK, PostFull}, 2'b01);
        tick;
        tick;
        chk("d2 w3 still stalled", {PostACK, PostFull, IOREQ}, 3'b011);
        e = sb.pop_front();
        chk("d2 head", {IOA, IOD, IOnUDS, IOnLDS}, e);
        IOACK = 1'b1;
        tick;
        IOACK = 1'b0;
        chk("d2 pop defers push", {PostACK, PostFull}, 2'b00);
        tick;
        chk("d2 w3 ack", {PostACK, PostFull}, 2'b11);
        sb.push_back({A, D, 2'b00});
        BACT = 1'b0;
        tick;
        IOPWCS = 1'b0; nWE = 1'b1;
        drain_one("d2 second");
        drain_one("d2 third");
        tick;
        chk("d2 empty", PostEmpty, 1);
`else
        nUDS = 1'b0; nLDS = 1'b0; nWE = 1'b0; IOPWCS = 1'b1;
        A = 23'h000200; D = 16'h00A1; BACT = 1'b1;
        tick;
        chk("d1 w1 ack", {PostACK, PostFull}, 2'b11);
        sb.push_back({A, D, 2'b00});
        BACT = 1'b0;
        tick;
        A = 23'h000202; D = 16'h00A2; BACT = 1'b1;
        tick;
        chk("d1 w2 stall", {PostACK, PostFull}, 2'b01);
        tick;
        tick;
        chk("d1 w2 still stalled", {PostACK, IOREQ}, 2'b01);
        e = sb.pop_front();
        chk("d1 head", {IOA, IOD, IOnUDS, IOnLDS}, e);
        IOACK = 1'b1;
        tick;
        IOACK = 1'b0;
        chk("d1 pop defers push", {PostACK, PostFull}, 2'b00);
        tick;
        chk("d1 w2 ack", {PostACK, PostFull}, 2'b11);
        sb.push_back({A, D, 2'b00});
        BACT = 1'b0;
        tick;
        IOPWCS = 1'b0; nWE = 1'b1;
        drain_one("d1 second");
`endif

        // IOACK held high: every entry gets a one-cycle IOREQ followed by a low cycle
        IOACK = 1'b1; left = 3; gap = 1'b0; prev = 1'b0; highs = 0; viol = 0;
        nUDS = 1'b0; nLDS = 1'b0; nWE = 1'b0; IOPWCS = 1'b1;
        tick;
        for (int c = 0; c < 40; c++) begin
            A = 23'h001000 + 23'(left); D = 16'h0A00 + 16'(left);
            BACT = (left > 0) && !gap;
            tick;
            if (BACT && PostACK) begin
                sb.push_back({A, D, 2'b00});
                left--;
                gap = 1'b1;
            end else gap = 1'b0;
            if (IOREQ) begin
                if (prev) viol++;
                highs++;
                e = (sb.size() > 0) ? sb.pop_front() : '1;
                chk($sformatf("burst entry %0d", highs), {IOA, IOD, IOnUDS, IOnLDS}, e);
            end
            prev = IOREQ;
        end
        BACT = 1'b0; IOACK = 1'b0; IOPWCS = 1'b0; nWE = 1'b1;
        chk("burst gaps", viol, 0);
        chk("burst count", highs, 3);
        chk("burst empty", PostEmpty, 1);

        // reset while a request is outstanding
        for (int k = 0; k < DEPTH; k++) begin
            wr(23'h002000 + 23'(k), 16'hC000 + 16'(k), 1'b0, 1'b0, 1'b0, 1'b1, ak);
            chk($sformatf("rst fill %0d", k), ak, 1);
        end
        chk("rst in req", IOREQ, 1);
        #2;
        nRES = 1'b0;
        #1;
        chk("rst drops req", {IOREQ, PostEmpty, PostFull, PostACK, IOnUDS, IOnLDS}, 6'b010011);
        chk("rst clears io", {IOA, IOD}, 0);
        #3;
        nRES = 1'b1;
        sb.delete();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (IOREQ || !PostEmpty) bad++;
        end
        chk("no replay", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
